// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the per-class queue bank that feeds the round-robin
// arbiter: default geometry, flow-control thresholds, the number of queues in
// the bank, err_code bit positions and the encoding of count update actions.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DATA_BITS       = 8;
  localparam int FIFO_ADDR_BITS       = 2;
  localparam int FIFO_ALMOST_FULL_TH  = 3;
  localparam int FIFO_ALMOST_EMPTY_TH = 1;

  // Number of queues in the bank; the arbiter's buf_empty vector is this wide.
  localparam int FIFO_QUEUE_COUNT     = 4;

  // Bit positions inside err_code (sticky-error build only).
  localparam int ERR_OVF_BIT          = 0;
  localparam int ERR_UDF_BIT          = 1;

  // Count update selected by {push accepted, pop accepted}.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_DEC  = 2'b01,
    CNT_INC  = 2'b10,
    CNT_BOTH = 2'b11
  } cnt_op_e;

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Dual-port register file, 2**ADDR_BITS words of DATA_BITS. Synchronous write,
// synchronous registered read. Storage is not reset; only the read register is.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset (read register only)
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable, loads rdata_o from raddr_i
//   raddr_i  in   read address
//   rdata_o  out  registered read data, holds when re_i is low
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_BITS = FIFO_DATA_BITS,
  parameter int ADDR_BITS = FIFO_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] rdata_q;

  // Storage write port; deliberately has no reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port. A same-edge write to the read address returns the
  // old word, which is what a full FIFO doing push+pop needs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= {DATA_BITS{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_queue.sv
// -----------------------------------------------------------------------------
// fifo_queue
// Parameterised synchronous FIFO, one per traffic class upstream of the
// round-robin arbiter. Registered read data with a one-cycle valid strobe,
// combinational occupancy flags and an overflow/underflow error output.
//
// Build option: define FIFO_ERR_STICKY_EN to make error sticky until reset and
// to add the err_code[1:0] output (bit0 overflow seen, bit1 underflow seen).
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   enb           in   block enable; low freezes all state
//   push          in   write request
//   data_in       in   write data
//   pop           in   read request
//   data_out      out  registered read data
//   valid_out     out  data_out holds a word popped on the previous edge
//   empty         out  count == 0
//   full          out  count == depth
//   almost_empty  out  count <= ALMOST_EMPTY_TH
//   almost_full   out  count >= ALMOST_FULL_TH
//   error         out  overflow/underflow indication
//   err_code      out  sticky {underflow, overflow} (FIFO_ERR_STICKY_EN only)
// -----------------------------------------------------------------------------
module fifo_queue
  import fifo_pkg::*;
#(
  parameter int DATA_BITS       = FIFO_DATA_BITS,
  parameter int ADDR_BITS       = FIFO_ADDR_BITS,
  parameter int ALMOST_FULL_TH  = FIFO_ALMOST_FULL_TH,
  parameter int ALMOST_EMPTY_TH = FIFO_ALMOST_EMPTY_TH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 error
`ifdef FIFO_ERR_STICKY_EN
  ,
  output logic [1:0]           err_code
`endif
);

  localparam logic [ADDR_BITS:0] DEPTH_C = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] AF_TH_C = (ADDR_BITS+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_BITS:0] AE_TH_C = (ADDR_BITS+1)'(ALMOST_EMPTY_TH);

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
`ifdef FIFO_ERR_STICKY_EN
  logic [1:0]           err_code_q, err_code_d;
`endif

  logic pop_acc_s;
  logic push_acc_s;
  logic ovf_s;
  logic udf_s;

  // Flags decode straight from count so they track it in the same cycle.
  assign empty        = (count_q == {(ADDR_BITS+1){1'b0}});
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= AE_TH_C);
  assign almost_full  = (count_q >= AF_TH_C);

  // A pop is never accepted from an empty queue (no write-through), while a
  // push into a full queue is accepted only if a pop frees a slot this edge.
  assign pop_acc_s  = enb & pop & ~empty;
  assign push_acc_s = enb & push & (~full | pop_acc_s);
  assign ovf_s      = enb & push & full & ~pop_acc_s;
  assign udf_s      = enb & pop & empty;

  // Next-state for pointers, occupancy, valid strobe and error tracking.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = pop_acc_s;
    error_d  = error_q;
`ifdef FIFO_ERR_STICKY_EN
    err_code_d = err_code_q;
`endif

    if (push_acc_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_acc_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case (cnt_op_e'({push_acc_s, pop_acc_s}))
      CNT_INC:  count_d = count_q + 1'b1;
      CNT_DEC:  count_d = count_q - 1'b1;
      CNT_HOLD: count_d = count_q;
      CNT_BOTH: count_d = count_q;
      default:  count_d = count_q;
    endcase

`ifdef FIFO_ERR_STICKY_EN
    err_code_d[ERR_OVF_BIT] = err_code_q[ERR_OVF_BIT] | ovf_s;
    err_code_d[ERR_UDF_BIT] = err_code_q[ERR_UDF_BIT] | udf_s;
    error_d                 = error_q | ovf_s | udf_s;
`else
    error_d = ovf_s | udf_s;
`endif
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {ADDR_BITS{1'b0}};
      rd_ptr_q <= {ADDR_BITS{1'b0}};
      count_q  <= {(ADDR_BITS+1){1'b0}};
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
`ifdef FIFO_ERR_STICKY_EN
      err_code_q <= 2'b00;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
`ifdef FIFO_ERR_STICKY_EN
      err_code_q <= err_code_d;
`endif
    end
  end

  fifo_mem #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (push_acc_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .re_i    (pop_acc_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out)
  );

  assign valid_out = valid_q;
  assign error     = error_q;
`ifdef FIFO_ERR_STICKY_EN
  assign err_code  = err_code_q;
`endif

endmodule
